// File: rtl/servant_uart_tx_ctrl.sv
// Wishbone-slave 8N1 UART transmitter with a byte queue. Build with SERVANT_UART_TX_FIFO_EN
// for a 2^FIFO_AW-entry FIFO; without it the queue is a single holding register.
module servant_uart_tx_ctrl #(
  parameter int BAUD_DIV = 1736,
  parameter int FIFO_AW  = 3
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_busy;
  logic        r_ack, r_held, r_ovf;
  logic [31:0] r_rdt;

  logic        w_req, w_wr_data, w_wr_stat, w_rd_stat;
  logic        w_push, w_pop, w_full, w_empty, w_empty_nxt, w_bit_end;
  logic [7:0]  w_head;
  logic        w_unused;

  // Handshake: a request is a stb sampled while no ack is in flight and the previous
  // request's stb has been released; it is acked exactly one cycle later, once.
  assign w_req     = i_wb_stb & ~r_ack & ~r_held;
  assign w_wr_data = w_req & i_wb_we & ~i_wb_adr;
  assign w_wr_stat = w_req & i_wb_we & i_wb_adr;
  assign w_rd_stat = w_req & ~i_wb_we & i_wb_adr;
  assign w_push    = w_wr_data & ~w_full;
  assign w_bit_end = (r_cnt == 16'd0);
  assign w_unused  = ^{i_wb_dat[31:8], i_wb_dat[1:0]};

`ifdef SERVANT_UART_TX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;

  assign w_full     = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                      (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_head     = r_mem[r_rptr[FIFO_AW-1:0]];
  assign w_wptr_nxt = r_wptr + {{FIFO_AW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{FIFO_AW{1'b0}}, w_pop};
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= i_wb_dat[7:0];
  end
`else
  localparam int unused_fifo_aw = FIFO_AW;

  logic       r_hold_vld;
  logic [7:0] r_hold;

  assign w_full      = r_hold_vld;
  assign w_empty     = ~r_hold_vld;
  assign w_head      = r_hold;
  assign w_empty_nxt = ~((r_hold_vld & ~w_pop) | w_push);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_hold_vld <= 1'b0;
      r_hold     <= 8'd0;
    end else begin
      r_hold_vld <= (r_hold_vld & ~w_pop) | w_push;
      if (w_push) r_hold <= i_wb_dat[7:0];
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_cnt_nxt   = BAUD_LOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_nxt   = 3'd0;
          w_cnt_nxt   = BAUD_LOAD;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = BAUD_LOAD;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        // Chaining straight into START keeps back-to-back frames gapless.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_cnt_nxt   = BAUD_LOAD;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_START)     w_tx_nxt = 1'b0;
    else if (w_state_nxt == S_DATA) w_tx_nxt = w_shift_nxt[0];
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_shift <= 8'd0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_held  <= 1'b0;
      r_rdt   <= 32'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) | ~w_empty_nxt;
      r_ack   <= w_req;
      r_held  <= i_wb_stb & (r_held | r_ack);
      r_rdt   <= w_rd_stat ? {29'd0, r_ovf, w_full, r_busy} : 32'd0;
      if (w_wr_data & w_full)              r_ovf <= 1'b1;
      else if (w_wr_stat & i_wb_dat[2])    r_ovf <= 1'b0;
    end
  end

  assign o_wb_rdt    = r_rdt;
  assign o_wb_ack    = r_ack;
  assign o_tx        = r_tx;
  assign o_busy      = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_servant_uart_tx_ctrl.sv
// Bench for servant_uart_tx_ctrl: line monitor + byte scoreboard, table of single frames,
// hand sequences for bus/overflow/reset corners, and randomized bursts.
module tb_servant_uart_tx_ctrl;

  localparam int BD = 4;
  localparam int FRAME = 10 * BD;
`ifdef SERVANT_UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        i_wb_adr = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack, o_tx, o_busy;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic ovf_m = 1'b0;

  logic [7:0] exp_q[$];
  logic [9:0] line_q[$];
  int         start_q[$];

  typedef struct {
    logic [31:0] dat;
    logic [9:0]  line;
  } vec_t;
  vec_t vecs[5];

  servant_uart_tx_ctrl #(.BAUD_DIV(BD), .FIFO_AW(3)) dut (
    .wb_clk(clk), .wb_rst(wb_rst), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .i_wb_we(i_wb_we), .i_wb_stb(i_wb_stb), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .o_tx(o_tx), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] st(input logic ovf, input logic full, input logic busy);
    return {29'd0, ovf, full, busy};
  endfunction

  // One bus transaction; at>0 schedules stb to be first seen in cycle 'at'.
  task automatic bus(input logic adr, input logic we, input logic [31:0] dat, input int at,
                     output logic [31:0] rdt, output int t0);
    int lat;
    @(posedge clk); #1;
    while (cyc < at) begin @(posedge clk); #1; end
    if (at > 0) chk("sched", 32'(cyc), 32'(at));
    i_wb_adr = adr; i_wb_we = we; i_wb_dat = dat; i_wb_stb = 1'b1;
    t0 = cyc; lat = -1; rdt = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_wb_ack) begin lat = cyc - t0; rdt = o_wb_rdt; break; end
    end
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    chk("ack_latency", 32'(lat), 32'd1);
  endtask

  task automatic wr_byte(input logic [7:0] b, input int at, output int t0);
    logic [31:0] r;
    bus(1'b0, 1'b1, ($urandom() & 32'hFFFF_FF00) | 32'(b), at, r, t0);
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    logic [31:0] r; int t;
    bus(1'b1, 1'b0, $urandom(), 0, r, t);
    chk(name, r, exp);
  endtask

  task automatic wait_idle(output int t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (o_busy && n < 2000);
    t = o_busy ? -1 : cyc;
  endtask

  // Line monitor: decodes 8N1 frames from o_tx and feeds the scoreboard.
  initial begin
    int cnt, glitch;
    logic [9:0] bits;
    logic active;
    active = 1'b0; cnt = 0; glitch = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (wb_rst) active = 1'b0;
      else begin
        if (!active && o_tx === 1'b0) begin
          active = 1'b1; cnt = 0; glitch = 0; bits = '0;
          start_q.push_back(cyc);
        end
        if (active) begin
          if (cnt % BD == 0) bits[cnt / BD] = o_tx;
          else if (o_tx !== bits[cnt / BD]) glitch++;
          cnt++;
          if (cnt == FRAME) begin
            active = 1'b0;
            line_q.push_back(bits);
            chk("frame_shape", {29'd0, glitch != 0, bits[9], bits[0]}, 32'b010);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL sb_extra_frame actual=0x%0h required=none", bits[8:1]);
            end else begin
              chk("sb_byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
            end
          end
        end
      end
    end
  end

  initial begin
    int t0, t1, td, acc, k, n0;
    logic [31:0] r, d;
    logic [7:0] b;

    vecs[0] = '{dat: 32'h0000_0055, line: 10'b1010101010};
    vecs[1] = '{dat: 32'hDEAD_BE41, line: 10'b1010000010};
    vecs[2] = '{dat: 32'hFFFF_FF00, line: 10'b1000000000};
    vecs[3] = '{dat: 32'h0000_00A5, line: 10'b1101001010};
    vecs[4] = '{dat: 32'h1234_56FF, line: 10'b1111111110};

    // Reset held 7 cycles
    repeat (7) @(posedge clk);
    #1 wb_rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", {31'd0, o_tx}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'd0);
    rd_status("rst_status", 32'd0);
    bus(1'b0, 1'b0, 32'hFFFF_FFFF, 0, r, t0);
    chk("data_read_zero", r, 32'd0);

    // Table: single frames from idle
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].dat[7:0]);
      start_q.delete(); line_q.delete();
      bus(1'b0, 1'b1, vecs[i].dat, 0, r, t0);
      wait_idle(td);
      chk("vec_start", 32'(start_q.size() > 0 ? start_q[0] : -1), 32'(t0 + 2));
      chk("vec_line", {22'd0, line_q.size() > 0 ? line_q[0] : 10'h3FF}, {22'd0, vecs[i].line});
      chk("vec_busy_drop", 32'(td), 32'(t0 + 2 + FRAME));
    end

    // Back-to-back frames, no idle gap
    start_q.delete();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    wr_byte(8'h41, 0, t0);
    wr_byte(8'h42, 0, t1);
    wait_idle(td);
    chk("b2b_nframes", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) chk("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));
    chk("b2b_busy_drop", 32'(td), 32'(t0 + 2 + 2 * FRAME));

    // Overflow: 10 writes while the first frame is on the line
    acc = DEPTH + 1;
    for (int j = 0; j < 10; j++) begin
      b = 8'(8'h60 + j);
      wr_byte(b, 0, t1);
      if (j == 0) t0 = t1;
      if (j < acc) exp_q.push_back(b);
    end
    ovf_m = 1'b1;
    rd_status("ovf_status", st(1'b1, 1'b1, 1'b1));
    bus(1'b1, 1'b1, 32'h0000_0004, 0, r, t1);
    ovf_m = 1'b0;
    rd_status("ovf_cleared", st(1'b0, 1'b1, 1'b1));
    wait_idle(td);
    chk("ovf_busy_drop", 32'(td), 32'(t0 + 2 + acc * FRAME));

    // Held stb on a STATUS read: one ack only
    @(posedge clk); #1;
    i_wb_adr = 1'b1; i_wb_we = 1'b0; i_wb_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin @(posedge clk); #1 i_wb_stb = 1'b0; end
      @(negedge clk);
      chk($sformatf("hold_ack_%0d", i), {31'd0, o_wb_ack}, {31'd0, i == 1});
      chk($sformatf("hold_rdt_%0d", i), o_wb_rdt, 32'd0);
    end

    // Write landing in the pop cycle while full is dropped; one after it is accepted
    wr_byte(8'h11, 0, t0);
    exp_q.push_back(8'h11);
    for (int j = 0; j < DEPTH; j++) begin
      wr_byte(8'(8'h20 + j), 0, t1);
      exp_q.push_back(8'(8'h20 + j));
    end
    wr_byte(8'hEE, t0 + 2 + FRAME - 1, t1);
    wr_byte(8'h77, t0 + 2 + FRAME + 1, t1);
    exp_q.push_back(8'h77);
    ovf_m = 1'b1;
    rd_status("popcyc_status", st(1'b1, 1'b1, 1'b1));
    bus(1'b1, 1'b1, 32'hFFFF_FFFF, 0, r, t1);
    ovf_m = 1'b0;
    wait_idle(td);
    chk("popcyc_busy_drop", 32'(td), 32'(t0 + 2 + (DEPTH + 2) * FRAME));

    // Reset during data bit 3 aborts the frame and flushes the queue
    wr_byte(8'h3C, 0, t0);
    wr_byte(8'h99, 0, t1);
    @(posedge clk); #1;
    while (cyc < t0 + 2 + 5 * BD - 3) begin @(posedge clk); #1; end
    wb_rst = 1'b1; exp_q.delete(); ovf_m = 1'b0;
    @(posedge clk); #1 wb_rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", {31'd0, o_tx}, 32'd1);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    n0 = start_q.size();
    repeat (3 * FRAME) @(negedge clk);
    chk("midrst_no_frame", 32'(start_q.size()), 32'(n0));
    rd_status("midrst_status", 32'd0);
    exp_q.push_back(8'hC3);
    wr_byte(8'hC3, 0, t0);
    wait_idle(td);
    chk("midrst_fresh_start", 32'(start_q.size() > n0 ? start_q[n0] : -1), 32'(t0 + 2));

    // Randomized bursts from idle
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(1, DEPTH + 3);
      acc = (k < DEPTH + 1) ? k : DEPTH + 1;
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom_range(0, 255));
        wr_byte(b, 0, t1);
        if (j == 0) t0 = t1;
        if (j < acc) exp_q.push_back(b);
        else ovf_m = 1'b1;
      end
      rd_status("rnd_status", st(ovf_m, acc - 1 == DEPTH, 1'b1));
      d = $urandom();
      bus(1'b1, 1'b1, d, 0, r, t1);
      if (d[2]) ovf_m = 1'b0;
      rd_status("rnd_status2", st(ovf_m, acc - 1 == DEPTH, 1'b1));
      wait_idle(td);
      chk("rnd_busy_drop", 32'(td), 32'(t0 + 2 + acc * FRAME));
    end
    rd_status("final_status", st(ovf_m, 1'b0, 1'b0));

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
